// File: rtl/clk_gen_pkg.sv
// Shared types and constants for the clk_div_gen programmable clock generator.
// The dither LFSR constants are only consumed when CLK_DIV_DITHER_EN is defined.
package clk_gen_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int MIN_PERIOD = 2;
  localparam int LFSR_W     = 16;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/clk_gen_lfsr.sv
// 16-bit Fibonacci LFSR used to add 0/1 cycle period jitter.
// Advances once per asserted step; bit_o is the low state bit.
module clk_gen_lfsr
  import clk_gen_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic step,
  output logic bit_o
);

  logic [LFSR_W-1:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else if (step) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign bit_o = lfsr_q[0];

endmodule

// File: rtl/clk_div_gen.sv
// Programmable divided-clock generator with shadowed, boundary-applied config.
// Optional period dither enabled by defining CLK_DIV_DITHER_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | stopped, cnt held at 0, outputs low, config applies at once
// ST_RUN   | counting 0..period-1 and wrapping while en is high
// ST_DRAIN | en dropped mid-period; finish this period then go idle
module clk_div_gen
  import clk_gen_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int RST_PERIOD = 2,
  parameter int RST_HIGH   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             clk_out,
  output logic             tick,
  output logic             running
);

  localparam logic [CNT_W-1:0] MIN_PER_C = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] RST_PER_C =
    (RST_PERIOD < MIN_PERIOD) ? CNT_W'(MIN_PERIOD) : CNT_W'(RST_PERIOD);
  localparam logic [CNT_W-1:0] RST_HIGH_C = CNT_W'(RST_HIGH);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] per_a, high_a;
  logic [CNT_W-1:0] per_s, high_s;
  logic             pend;

  logic             active;
  logic             boundary;
  logic             accept;
  logic             apply;
  logic             dith;
  logic [CNT_W-1:0] per_in;
  logic [CNT_W:0]   per_eff;
  logic [CNT_W:0]   per_last;

`ifdef CLK_DIV_DITHER_EN
  clk_gen_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (boundary),
    .bit_o (dith)
  );
`else
  assign dith = 1'b0;
`endif

  assign active    = (state != ST_IDLE);
  assign running   = active;
  assign cfg_ready = !pend;

  assign per_eff  = {1'b0, per_a} + {{CNT_W{1'b0}}, dith};
  assign per_last = per_eff - {{CNT_W{1'b0}}, 1'b1};
  assign boundary = active && ({1'b0, cnt} == per_last);

  assign accept = cfg_valid && !pend;
  // Shadow copies to active only while stopped or on the last count of a
  // period, so a waveform period is never cut short or stretched.
  assign apply  = pend && (!active || boundary);
  assign per_in = (cfg_period < MIN_PER_C) ? MIN_PER_C : cfg_period;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (en) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!en) state_nxt = boundary ? ST_IDLE : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (en)            state_nxt = ST_RUN;
        else if (boundary) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      per_a   <= RST_PER_C;
      high_a  <= RST_HIGH_C;
      per_s   <= RST_PER_C;
      high_s  <= RST_HIGH_C;
      pend    <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      if (!active || boundary) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end

      clk_out <= active && (cnt < high_a);
      tick    <= active && (cnt == '0);

      if (apply) begin
        per_a  <= per_s;
        high_a <= high_s;
      end

      // accept and apply are exclusive: accept needs pend low, apply needs it high.
      if (accept) begin
        per_s  <= per_in;
        high_s <= cfg_high;
      end

      pend <= accept || (pend && !apply);
    end
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: per-cycle reference model plus
// table-driven waveform patterns and hand-written corner sequences.
module tb_clk_div_gen;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         cfg_valid = 1'b0;
  logic [W-1:0] cfg_period = '0;
  logic [W-1:0] cfg_high = '0;
  logic         cfg_ready;
  logic         clk_out;
  logic         tick;
  logic         running;

  always #5 clk = ~clk;

  clk_div_gen #(
    .CNT_W      (W),
    .RST_PERIOD (2),
    .RST_HIGH   (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .clk_out    (clk_out),
    .tick       (tick),
    .running    (running)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0=stopped 1=running 2=finishing period.
  int m_mode, m_pos, m_per, m_high, m_sper, m_shigh;
  bit m_pend, m_out, m_tick;

  typedef struct {
    int       per;
    int       high;
    bit [7:0] out_pat;
    bit [7:0] tick_pat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_per = 2; m_high = 1;
    m_sper = 2; m_shigh = 1; m_pend = 0; m_out = 0; m_tick = 0;
  endtask

  task automatic step();
    int  n_mode, n_pos, n_per, n_high, n_sper, n_shigh, cp;
    bit  n_pend, n_out, n_tick, last, acc;
    if (!rst_n) begin
      n_mode = 0; n_pos = 0; n_per = 2; n_high = 1;
      n_sper = 2; n_shigh = 1; n_pend = 0; n_out = 0; n_tick = 0;
    end else begin
      last    = (m_mode != 0) && (m_pos == m_per - 1);
      acc     = cfg_valid && !m_pend;
      n_out   = (m_mode != 0) && (m_pos < m_high);
      n_tick  = (m_mode != 0) && (m_pos == 0);
      n_per   = m_per;  n_high  = m_high;
      n_sper  = m_sper; n_shigh = m_shigh;
      n_pend  = m_pend;
      if (m_pend && (m_mode == 0 || last)) begin
        n_per = m_sper; n_high = m_shigh; n_pend = 0;
      end
      if (acc) begin
        cp = int'(cfg_period);
        n_sper  = (cp < 2) ? 2 : cp;
        n_shigh = int'(cfg_high);
        n_pend  = 1;
      end
      if (m_mode == 0) begin
        n_pos  = 0;
        n_mode = en ? 1 : 0;
      end else begin
        n_pos = last ? 0 : m_pos + 1;
        if (en)          n_mode = 1;
        else if (last)   n_mode = 0;
        else             n_mode = 2;
      end
    end
    @(posedge clk);
    #1;
    m_mode = n_mode; m_pos = n_pos; m_per = n_per; m_high = n_high;
    m_sper = n_sper; m_shigh = n_shigh; m_pend = n_pend;
    m_out = n_out; m_tick = n_tick;
    chk("model_clk_out", {31'd0, clk_out}, {31'd0, m_out});
    chk("model_tick", {31'd0, tick}, {31'd0, m_tick});
    chk("model_running", {31'd0, running}, {31'd0, (m_mode != 0)});
    chk("model_cfg_ready", {31'd0, cfg_ready}, {31'd0, !m_pend});
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic cfg_idle(input int p, input int h);
    cfg_valid = 1'b1; cfg_period = W'(p); cfg_high = W'(h);
    step();
    cfg_valid = 1'b0;
    step();
  endtask

  task automatic wait_pos(input int p);
    int n = 0;
    while (m_pos != p && n < 40) begin
      step(); n++;
    end
    chk("wait_pos_bound", {31'd0, (n < 40)}, 32'd1);
  endtask

  initial begin
    bit [3:0] pat;
    int       n;

    vecs[0] = '{5, 2, 8'h63, 8'h21};
    vecs[1] = '{4, 1, 8'h11, 8'h11};
    vecs[2] = '{0, 0, 8'h00, 8'h55};
    vecs[3] = '{4, 7, 8'hFF, 8'h11};
    vecs[4] = '{1, 1, 8'h55, 8'h55};
    vecs[5] = '{3, 3, 8'hFF, 8'h49};
    vecs[6] = '{6, 3, 8'hC7, 8'h41};

    model_reset();
    do_reset();
    chk("rst_clk_out", {31'd0, clk_out}, 32'd0);
    chk("rst_tick", {31'd0, tick}, 32'd0);
    chk("rst_running", {31'd0, running}, 32'd0);
    chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);

    foreach (vecs[i]) begin
      do_reset();
      cfg_idle(vecs[i].per, vecs[i].high);
      en = 1'b1;
      step(); step();
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("vec%0d_clk_out%0d", i, k), {31'd0, clk_out}, {31'd0, vecs[i].out_pat[k]});
        chk($sformatf("vec%0d_tick%0d", i, k), {31'd0, tick}, {31'd0, vecs[i].tick_pat[k]});
        step();
      end
      en = 1'b0;
    end

    // Mid-period reconfiguration from 5/2 to 4/1, with a second offer stalled.
    do_reset();
    cfg_idle(5, 2);
    en = 1'b1;
    step(); step(); step();
    wait_pos(1);
    cfg_valid = 1'b1; cfg_period = W'(4); cfg_high = W'(1);
    step();
    chk("reconf_ready_low", {31'd0, cfg_ready}, 32'd0);
    cfg_period = W'(9); cfg_high = W'(9);
    step();
    chk("reconf_stall_ready", {31'd0, cfg_ready}, 32'd0);
    cfg_valid = 1'b0;
    n = 0;
    while (tick !== 1'b1 && n < 20) begin
      step(); n++;
    end
    chk("reconf_tick_bound", {31'd0, (n < 20)}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      pat[k] = clk_out;
      step();
    end
    chk("reconf_pattern", {28'd0, pat}, 32'h1);
    chk("reconf_ready_back", {31'd0, cfg_ready}, 32'd1);

    // en dropped at cnt=1 of a period-6 waveform finishes the period.
    do_reset();
    cfg_idle(6, 3);
    en = 1'b1;
    step(); step(); step();
    wait_pos(1);
    en = 1'b0;
    step();
    n = 1;
    while (running === 1'b1 && n < 20) begin
      step(); n++;
    end
    chk("drain_cycles", n, 5);
    chk("drain_clk_out", {31'd0, clk_out}, 32'd0);
    step();
    chk("drain_idle_tick", {31'd0, tick}, 32'd0);

    // Reset mid-run with a pending config; restart uses reset period/high.
    do_reset();
    cfg_idle(5, 2);
    en = 1'b1;
    step(); step(); step();
    cfg_valid = 1'b1; cfg_period = W'(7); cfg_high = W'(4);
    step();
    cfg_valid = 1'b0;
    rst_n = 1'b0;
    step();
    chk("midrst_clk_out", {31'd0, clk_out}, 32'd0);
    chk("midrst_tick", {31'd0, tick}, 32'd0);
    chk("midrst_running", {31'd0, running}, 32'd0);
    chk("midrst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    rst_n = 1'b1;
    step(); step();
    for (int k = 0; k < 4; k++) begin
      pat[k] = clk_out;
      step();
    end
    chk("midrst_restart_pattern", {28'd0, pat}, 32'h5);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) en = ~en;
      cfg_valid  = ($urandom_range(0, 3) == 0);
      cfg_period = W'($urandom_range(0, 9));
      cfg_high   = W'($urandom_range(0, 11));
      rst_n      = ($urandom_range(0, 499) != 0);
      step();
    end
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_div_gen.md
# clk_div_gen

Synthesizable programmable clock generator: divides the system clock into a registered output waveform with run-time programmable period and high time, sampled from a clock-enable style counter. Sits directly downstream of the bench clock source (`clk`) and drives divided clocks/strobes into consumer blocks; frequency/duty configuration mirrors the `freq`/`duty`/`jitter` knobs used at bench level. Reconfiguration is glitch-free, applied only at period boundaries.

## Interface
- `CNT_W`, 16: width of period/high-time counters (cycles of `clk`).
- `RST_PERIOD`, 2: period loaded at reset.
- `RST_HIGH`, 1: high time loaded at reset.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `en`  in  1  run request; level-sensitive.
- `cfg_valid`  in  1  new configuration offered.
- `cfg_ready`  out  1  shadow register free; transfer on `cfg_valid && cfg_ready`.
- `cfg_period`  in  CNT_W  period in `clk` cycles.
- `cfg_high`  in  CNT_W  high-phase length in `clk` cycles.
- `clk_out`  out  1  generated waveform, registered.
- `tick`  out  1  one-cycle pulse on first cycle of each period's high phase (or period start if high=0).
- `running`  out  1  high in RUN/DRAIN.

## Operation
- Active registers `per_a`, `high_a`; shadow `per_s`, `high_s`, `pend`.
- Period clamp: any `cfg_period` < 2 stored as 2.
- `high_a` = 0 -> `clk_out` constantly 0; `high_a` >= `per_a` -> constantly 1 while running.
- `cfg_ready` = !`pend`. Accepted config sets `pend`; copied to active at next period boundary (cnt == per_a-1) or immediately in IDLE; `pend` clears same cycle.
- Simultaneous accept and boundary: the just-accepted values do not apply until the following boundary (shadow written, `pend` set).
- States: IDLE (cnt=0, outputs 0) -> RUN when `en`=1. RUN: cnt counts 0..per_a-1, wraps to 0. `en`=0 in RUN -> DRAIN. DRAIN: finish current period; at boundary -> IDLE; `en`=1 again in DRAIN -> back to RUN, no period disturbed.
- Next `clk_out` = running && (cnt < high_a); `tick` next = running && cnt == 0.
- Counter arithmetic unsigned CNT_W; never exceeds per_a-1 (or per_a with dither).

## Timing
- Reset: `clk_out`=0, `tick`=0, `running`=0, `cfg_ready`=1, state IDLE, cnt=0, per_a=RST_PERIOD, high_a=RST_HIGH, pend=0.
- `en` sampled high at edge N (IDLE) -> cnt=0 and `running`=1 after edge N+1... precisely: state RUN after edge N; `clk_out`/`tick` first high after edge N+1.
- `clk_out` and `tick` lag counter by exactly one cycle.
- Config latency: applied on first period boundary after accept; new waveform visible from the next period's first cycle.
- Reset mid-run: all outputs to reset values after the reset edge; pending config discarded.

## Configuration
- `CLK_DIV_DITHER_EN` defined: 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 at reset) advances once per period; effective period = per_a + lfsr[0] (adds 0/1 cycle jitter); high time unchanged.
- Undefined: no LFSR, period exactly per_a; all period tests are cycle-exact.

## Structure
- Package `clk_gen_pkg`: state enum (IDLE, RUN, DRAIN), `CNT_W` default, LFSR seed/tap constants, minimum period constant.
- Sub-module `clk_gen_lfsr` (instantiated only under `CLK_DIV_DITHER_EN`), with `step` input and `bit_o` output.

## Test plan
- period 5, high 2, en=1 -> `clk_out` pattern 1,1,0,0,0 repeating; `tick` every 5 cycles aligned with first 1.
- Running at 5/2, offer 4/1 mid-period -> `cfg_ready` low until boundary; next period 1,0,0,0; second offer while pending stalls.
- en=0 at cnt=1 of period 6 -> remaining cycles completed, then `running`=0, `clk_out`=0, IDLE.
- high=0 -> `clk_out` stays 0, `tick` still every period; high=7 with period 4 -> `clk_out` stays 1.
- cfg_period=1 -> behaves as period 2 (high 1 gives 1,0 toggle = clk/2).
- rst_n low at arbitrary RUN cycle with pend=1 -> next cycle all outputs 0, `cfg_ready`=1, restart uses RST_PERIOD/RST_HIGH.
